// File: rtl/ram16k_core.sv
// 16K x 16 data memory for the Hack-style CPU, built as a bank hierarchy:
// ram16k_core -> 4 x ram4k -> 8 x ram512 -> 8 x ram64 -> 8 x ram8.
// Combinational read, synchronous write. Reset gates both the read data and
// the write enable; it never clears the array.

// Leaf bank: eight words with a combinational read port and a clocked write port.
module ram8 #(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic [DATA_W-1:0] in,
  input  logic [2:0]        addr,
  input  logic              ld,
  output logic [DATA_W-1:0] out
);

  // Zero at power-up through the declaration initialiser, which maps onto
  // memory init in FPGA flows.
  logic [DATA_W-1:0] mem [8] = '{default: '0};

  // Store the write data into the addressed word when this bank is selected.
  always_ff @(posedge clk) begin
    if (ld) begin
      mem[addr] <= in;
    end
  end

  // Drive the addressed word straight out; the read has no latency.
  always_comb begin
    out = mem[addr];
  end

endmodule

// 64 words: eight ram8 banks selected by addr[5:3].
module ram64 #(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic [DATA_W-1:0] in,
  input  logic [5:0]        addr,
  input  logic              ld,
  output logic [DATA_W-1:0] out
);

  logic [7:0]        sel_ld;
  logic [DATA_W-1:0] sub_out [8];

  // Route the load to exactly one sub-bank.
  always_comb begin
    sel_ld             = '0;
    sel_ld[addr[5:3]]  = ld;
  end

  for (genvar gi = 0; gi < 8; gi++) begin : g_bank
    ram8 #(.DATA_W(DATA_W)) u_ram8 (
      .clk  (clk),
      .in   (in),
      .addr (addr[2:0]),
      .ld   (sel_ld[gi]),
      .out  (sub_out[gi])
    );
  end

  // Select the addressed sub-bank's read data.
  always_comb begin
    out = sub_out[addr[5:3]];
  end

endmodule

// 512 words: eight ram64 banks selected by addr[8:6].
module ram512 #(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic [DATA_W-1:0] in,
  input  logic [8:0]        addr,
  input  logic              ld,
  output logic [DATA_W-1:0] out
);

  logic [7:0]        sel_ld;
  logic [DATA_W-1:0] sub_out [8];

  // Route the load to exactly one sub-bank.
  always_comb begin
    sel_ld             = '0;
    sel_ld[addr[8:6]]  = ld;
  end

  for (genvar gi = 0; gi < 8; gi++) begin : g_bank
    ram64 #(.DATA_W(DATA_W)) u_ram64 (
      .clk  (clk),
      .in   (in),
      .addr (addr[5:0]),
      .ld   (sel_ld[gi]),
      .out  (sub_out[gi])
    );
  end

  // Select the addressed sub-bank's read data.
  always_comb begin
    out = sub_out[addr[8:6]];
  end

endmodule

// 4096 words: eight ram512 banks selected by addr[11:9].
module ram4k #(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic [DATA_W-1:0] in,
  input  logic [11:0]       addr,
  input  logic              ld,
  output logic [DATA_W-1:0] out
);

  logic [7:0]        sel_ld;
  logic [DATA_W-1:0] sub_out [8];

  // Route the load to exactly one sub-bank.
  always_comb begin
    sel_ld              = '0;
    sel_ld[addr[11:9]]  = ld;
  end

  for (genvar gi = 0; gi < 8; gi++) begin : g_bank
    ram512 #(.DATA_W(DATA_W)) u_ram512 (
      .clk  (clk),
      .in   (in),
      .addr (addr[8:0]),
      .ld   (sel_ld[gi]),
      .out  (sub_out[gi])
    );
  end

  // Select the addressed sub-bank's read data.
  always_comb begin
    out = sub_out[addr[11:9]];
  end

endmodule

// Top: four ram4k banks selected by addr[13:12]; addr[14] belongs to the
// memory-mapped I/O region and is decoded here so it never aliases low.
module ram16k_core #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned DEPTH  = 16384
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in,
  input  logic [ADDR_W-1:0] addr,
  input  logic              ld,
  output logic [DATA_W-1:0] out
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic              io_sel;
  logic              wr_en;
  logic [3:0]        sel_ld;
  logic [DATA_W-1:0] sub_out [4];
  logic [DATA_W-1:0] mem_out;

  // Qualify the load: a floating or unknown ld must never write, and neither
  // reset nor an I/O-region address may reach the array.
  always_comb begin
    io_sel = addr[ADDR_W-1];
    wr_en  = !rst && (ld === 1'b1) && !io_sel;
  end

  // Route the qualified load to exactly one 4K bank.
  always_comb begin
    sel_ld                       = '0;
    sel_ld[addr[IDX_W-1 -: 2]]   = wr_en;
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_bank
    ram4k #(.DATA_W(DATA_W)) u_ram4k (
      .clk  (clk),
      .in   (in),
      .addr (addr[IDX_W-3:0]),
      .ld   (sel_ld[gi]),
      .out  (sub_out[gi])
    );
  end

  // Pick the addressed bank, then force zero during reset or for I/O addresses.
  always_comb begin
    mem_out = sub_out[addr[IDX_W-1 -: 2]];
    out     = (rst || io_sel) ? '0 : mem_out;
  end

endmodule

// File: tb/tb_ram16k_core.sv
// Directed and randomized checks of ram16k_core against a flat-array model.
module tb_ram16k_core;

  logic        clk;
  logic        rst;
  logic [15:0] din;
  logic [14:0] addr;
  logic        ld;
  logic [15:0] dout;

  int unsigned passed = 0;
  int unsigned total  = 0;

  logic [15:0] model [16384];

  ram16k_core #(.DATA_W(16), .ADDR_W(15), .DEPTH(16384)) dut (
    .clk  (clk),
    .rst  (rst),
    .in   (din),
    .addr (addr),
    .ld   (ld),
    .out  (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] exp);
    total++;
    assert (dout === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, dout, exp);
  endtask

  function automatic logic [15:0] model_read(input logic [14:0] a, input logic r);
    if (r || a[14]) return 16'h0000;
    return model[a[13:0]];
  endfunction

  // One write cycle; the model applies the memory's rules at the edge.
  task automatic do_write(input logic [14:0] a, input logic [15:0] d, input logic r);
    @(negedge clk);
    addr = a; din = d; ld = 1'b1; rst = r;
    @(posedge clk);
    if (!r && !a[14]) model[a[13:0]] = d;
    #1;
    ld = 1'b0; rst = 1'b0;
  endtask

  task automatic do_read(input string tag, input logic [14:0] a);
    @(negedge clk);
    addr = a; ld = 1'b0;
    #1;
    check(tag, model_read(a, rst));
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) model[i] = 16'h0000;
    rst = 1'b0; ld = 1'b0; addr = '0; din = '0;

    // Power-up contents.
    for (int i = 0; i < 8; i++) do_read("powerup", 15'(i));

    // Single write and neighbours.
    do_write(15'h0005, 16'hBEEF, 1'b0);
    do_read("wr5", 15'h0005);
    check("wr5_const", 16'hBEEF);
    do_read("nb4", 15'h0004);
    check("nb4_const", 16'h0000);
    do_read("nb6", 15'h0006);

    // Extremes of the array.
    do_write(15'h3FFF, 16'h1234, 1'b0);
    do_write(15'h0000, 16'h5678, 1'b0);
    do_read("top", 15'h3FFF);
    check("top_const", 16'h1234);
    do_read("bottom", 15'h0000);
    check("bottom_const", 16'h5678);
    do_read("mid", 15'h1FFF);
    check("mid_const", 16'h0000);

    // I/O region write must not alias.
    do_write(15'h4005, 16'hFFFF, 1'b0);
    do_read("io_rd", 15'h4005);
    check("io_rd_const", 16'h0000);
    do_read("no_alias", 15'h0005);
    check("no_alias_const", 16'hBEEF);

    // Reset blocks writes and zeroes the read port, contents survive.
    @(negedge clk);
    rst = 1'b1; ld = 1'b1; addr = 15'h0005; din = 16'hAAAA;
    #1 check("rst_out0", 16'h0000);
    @(posedge clk); #1 check("rst_out1", 16'h0000);
    @(posedge clk); #1 check("rst_out2", 16'h0000);
    @(negedge clk);
    rst = 1'b0; ld = 1'b0;
    #1 check("after_rst", 16'hBEEF);

    // Read-during-write: old word before the edge, new word after it.
    @(negedge clk);
    addr = 15'h000A; din = 16'hCAFE; ld = 1'b1;
    #1 check("rdw_before", model[10]);
    @(posedge clk);
    model[10] = 16'hCAFE;
    #1 check("rdw_after", 16'hCAFE);
    ld = 1'b0;

    // Randomized writes/reads over a small window plus its I/O mirror.
    for (int n = 0; n < 300; n++) begin
      logic [14:0] a;
      logic [15:0] d;
      logic        r;
      a = 15'($urandom_range(0, 63));
      if ($urandom_range(0, 4) == 0) a[14] = 1'b1;
      if ($urandom_range(0, 5) == 0) a[13:12] = 2'($urandom_range(0, 3));
      d = 16'($urandom);
      r = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 1) == 0) do_write(a, d, r);
      else do_read("rand_rd", a);
    end

    // Unknown ld/addr for 100 ns: no word may change.
    @(negedge clk);
    ld = 1'bx; addr = 'x; din = 16'h9999;
    #100;
    @(negedge clk);
    ld = 1'b0; addr = '0;
    do_read("x_keep5", 15'h0005);
    do_read("x_keep_top", 15'h3FFF);
    for (int i = 0; i < 64; i++) do_read("x_keep_win", 15'(i));
    for (int b = 0; b < 4; b++)
      for (int i = 0; i < 64; i++) do_read("x_keep_bank", 15'((b << 12) | i));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
